// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the M-extension sequencer.
//   md_state_e      - sequencer state encoding (IDLE, WAIT, DONE)
//   DEF_*_CYCLES    - default multicycle budgets for multiply and divide
//   OPCODE_R, FUNCT7_MULDIV, F3_* - RV32M instruction field constants
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } md_state_e;

    localparam int DEF_MUL_CYCLES = 2;
    localparam int DEF_DIV_CYCLES = 8;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: purely combinational RV32M multiply/divide datapath.
//   opcode_i, funct7_i, funct3_i - instruction fields selecting the operation
//   op1_i, op2_i                 - rs1 / rs2 operands
//   result_o                     - selected result (0 when not an M-extension op)
//   is_muldiv_o                  - instruction decodes as an M-extension op
// All special cases (divide by zero, signed overflow) are produced here.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit FPGA = 1'b0
) (
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] result_o,
    output logic            is_muldiv_o
);

    assign is_muldiv_o = (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV);

    // Multiply: MULHU treats both operands unsigned, MULHSU only rs2.
    // MUL keeps the low word, which does not depend on signedness.
    logic            a_signed;
    logic            b_signed;
    logic [2*XLEN-1:0] product;

    assign a_signed = (funct3_i[1:0] != 2'b11);
    assign b_signed = ~funct3_i[1];

    if (FPGA) begin : g_mul_fpga
        // Sign-extended full-width product maps straight onto DSP cascades.
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        assign a_ext   = {{XLEN{a_signed & op1_i[XLEN-1]}}, op1_i};
        assign b_ext   = {{XLEN{b_signed & op2_i[XLEN-1]}}, op2_i};
        assign product = a_ext * b_ext;
    end else begin : g_mul_asic
        // Unsigned magnitude multiplier with a final conditional negate.
        logic              a_neg;
        logic              b_neg;
        logic [XLEN-1:0]   a_mag;
        logic [XLEN-1:0]   b_mag;
        logic [2*XLEN-1:0] p_mag;
        assign a_neg   = a_signed & op1_i[XLEN-1];
        assign b_neg   = b_signed & op2_i[XLEN-1];
        assign a_mag   = a_neg ? -op1_i : op1_i;
        assign b_mag   = b_neg ? -op2_i : op2_i;
        assign p_mag   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        assign product = (a_neg ^ b_neg) ? -p_mag : p_mag;
    end

    // Divide on magnitudes. The signed-overflow case falls out naturally:
    // |0x80000000| / 1 = 0x80000000 with no negation, remainder 0.
    logic            div_signed;
    logic            dvd_neg;
    logic            dvs_neg;
    logic            dvs_zero;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN-1:0] dvs_safe;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    assign div_signed = ~funct3_i[0];
    assign dvd_neg    = div_signed & op1_i[XLEN-1];
    assign dvs_neg    = div_signed & op2_i[XLEN-1];
    assign dvs_zero   = (op2_i == '0);
    assign dvd_mag    = dvd_neg ? -op1_i : op1_i;
    assign dvs_mag    = dvs_neg ? -op2_i : op2_i;
    // Keep the divider free of X when the divisor is zero.
    assign dvs_safe   = dvs_zero ? {{(XLEN-1){1'b0}}, 1'b1} : dvs_mag;
    assign q_mag      = dvd_mag / dvs_safe;
    assign r_mag      = dvd_mag % dvs_safe;
    assign quot       = dvs_zero ? '1    : ((dvd_neg ^ dvs_neg) ? -q_mag : q_mag);
    assign rem        = dvs_zero ? op1_i : (dvd_neg ? -r_mag : r_mag);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves result_o
        // unassigned; otherwise synthesis infers a latch.
        result_o = '0;
        if (is_muldiv_o) begin
            case (funct3_i)
                F3_MUL:                       result_o = product[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: result_o = product[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              result_o = quot;
                default:                      result_o = rem;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multicycle sequencer around muldiv_unit.
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   valid_i / ready_o          - request handshake from execute
//   op1_i, op2_i, funct3_i     - request operands and M-extension funct3
//   flush_i                    - kill the in-flight operation
//   valid_o / ready_i          - result handshake to writeback
//   result_o                   - registered result
//   busy_o                     - sequencer not idle (pipeline stall)
// Operands are registered on accept and held for a fixed number of cycles
// so the datapath may be constrained as a multicycle path.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit FPGA       = 1'b0,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [2:0]      funct3_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] result_q;
    logic            valid_q;
    logic [XLEN-1:0] unit_result;
    logic            unused_is_muldiv;
    logic            accept;

    // Ready follows writeback in DONE so a new request can issue in the same
    // cycle the previous result drains; a flush blocks any accept.
    assign ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & ready_i));
    assign accept  = valid_i & ready_o;

    muldiv_unit #(
        .XLEN (XLEN),
        .FPGA (FPGA)
    ) u_muldiv (
        .opcode_i    (OPCODE_R),
        .funct3_i    (funct3_q),
        .funct7_i    (FUNCT7_MULDIV),
        .op1_i       (op1_q),
        .op2_i       (op2_q),
        .result_o    (unit_result),
        .is_muldiv_o (unused_is_muldiv)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            // NOTE: operand registers are reset too, so the multicycle path
            // never launches from an unknown value after reset.
            op1_q    <= '0;
            op2_q    <= '0;
            funct3_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op1_q    <= op1_i;
                op2_q    <= op2_i;
                funct3_q <= funct3_i;
                cnt_q    <= funct3_i[2] ? DIV_LOAD : MUL_LOAD;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        result_q <= unit_result;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= valid_i ? WAIT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign busy_o   = (state_q != IDLE);

endmodule
